// File: rtl/high_speed_out_bus.sv
// Transmit end of a 4-phase req/ack bundled-data bus, fed from a small FIFO.
// Optional handshake watchdog: define HS_OUT_BUS_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for a FIFO word; pops the head into out_data
// SETUP   | out_data held, counting down data setup before request
// REQ     | request high, waiting for ack_s to rise
// RELEASE | request low, waiting for ack_s to fall
module high_speed_out_bus #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int SETUP_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          request,
    input  logic                          acknowledge,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          timeout
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int SCW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam logic [CW-1:0]  DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [SCW-1:0] SETUP_LOAD = SCW'(SETUP_CYCLES - 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        SETUP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("high_speed_out_bus: illegal parameter value");
    end

    typedef enum logic [1:0] {IDLE, SETUP, REQ, RELEASE} state_t;

    state_t                  state, state_nxt;
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count;
    logic                    push, load_out;
    logic                    ack_meta, ack_s;
    logic [SCW-1:0]          setup_cnt, setup_cnt_nxt;
    logic                    request_nxt;
    logic                    wd_expired;

    assign in_ready   = (count != DEPTH_C);
    assign push       = in_valid && in_ready;
    assign fifo_count = count;
    assign busy       = (state != IDLE) || (count != '0);

    // acknowledge comes from another clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= acknowledge;
            ack_s    <= ack_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (load_out)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, load_out})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

`ifdef HS_OUT_BUS_TIMEOUT_EN
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WW-1:0] WD_LOAD = WW'(TIMEOUT_CYCLES - 1);

    logic [WW-1:0] wd_cnt;

    assign wd_expired = (wd_cnt == '0);

    // reloaded on every state change, so it restarts on REQ and RELEASE entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt  <= WD_LOAD;
            timeout <= 1'b0;
        end else begin
            if (state_nxt != state)
                wd_cnt <= WD_LOAD;
            else if (wd_cnt != '0)
                wd_cnt <= wd_cnt - 1'b1;
            if ((state == REQ && !ack_s && wd_expired) ||
                (state == RELEASE && ack_s && wd_expired))
                timeout <= 1'b1;
        end
    end
`else
    assign wd_expired = 1'b0;
    assign timeout    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            request   <= 1'b0;
            out_data  <= '0;
            setup_cnt <= '0;
        end else begin
            state     <= state_nxt;
            request   <= request_nxt;
            setup_cnt <= setup_cnt_nxt;
            if (load_out)
                out_data <= mem[rd_ptr];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count != '0)             state_nxt = SETUP;
            SETUP:   if (setup_cnt == '0)         state_nxt = REQ;
            REQ:     if (ack_s || wd_expired)     state_nxt = RELEASE;
            RELEASE: if (!ack_s || wd_expired)    state_nxt = IDLE;
            default:                              state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_out      = (state == IDLE) && (count != '0);
        request_nxt   = (state_nxt == REQ);
        setup_cnt_nxt = setup_cnt;
        if (load_out)
            setup_cnt_nxt = SETUP_LOAD;
        else if (state == SETUP && setup_cnt != '0)
            setup_cnt_nxt = setup_cnt - 1'b1;
    end

endmodule

// File: tb/tb_high_speed_out_bus.sv
// Bench for high_speed_out_bus: directed pushes, a queue scoreboard popped on
// each request rise, and a receiver model with a 3-cycle acknowledge delay.
module tb_high_speed_out_bus;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [7:0] out_data;
    logic       request;
    logic       rx_ack = 1'b0;
    logic       man_ack = 1'b0;
    logic       acknowledge;
    logic       busy;
    logic [2:0] fifo_count;
    logic       timeout;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    bit         rx_en = 1'b0;

    logic       ack_m1, ack_sm;
    logic       prev_req, prev_act;
    logic [7:0] prev_out;
    logic [7:0] mon_exp;

    assign acknowledge = rx_ack | man_ack;

    high_speed_out_bus #(
        .DATA_WIDTH(8), .FIFO_DEPTH(4), .SETUP_CYCLES(1), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_data(out_data), .request(request),
        .acknowledge(acknowledge), .busy(busy), .fifo_count(fifo_count),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference view of the receiver-side synchronized acknowledge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_m1 <= 1'b0;
            ack_sm <= 1'b0;
        end else begin
            ack_m1 <= acknowledge;
            ack_sm <= ack_m1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req = 1'b0;
            prev_act = 1'b0;
            prev_out = out_data;
        end else begin
            if (request && !prev_req) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word_unexpected: got %0h expected none", out_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("word_order", out_data, mon_exp);
                    check("setup_before_req", prev_out, mon_exp);
                end
            end
            if ((request || ack_sm) && (prev_req || prev_act))
                check("out_stable", out_data, prev_out);
            prev_req = request;
            prev_act = ack_sm;
            prev_out = out_data;
        end
    end

    initial begin : rx_model
        int n;
        forever begin
            @(negedge clk);
            if (rx_en && rst_n && request) begin
                repeat (3) @(negedge clk);
                rx_ack = 1'b1;
                n = 0;
                while (request && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                check("ack_to_req_fall", n, 3);
                @(negedge clk);
                rx_ack = 1'b0;
            end
        end
    end

    task automatic push_word(input logic [7:0] d, input bit exp_acc);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        check("in_ready", in_ready, exp_acc);
        @(posedge clk);
        if (exp_acc)
            exp_q.push_back(d);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_req(input logic lvl, input int budget, input string name);
        int n = 0;
        while (request !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, request, lvl);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, 0);
    endtask

    initial begin : main
        int n;
        #12;
        check("rst_request", request, 0);
        check("rst_out_data", out_data, 0);
        check("rst_count", fifo_count, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);
        #10 rst_n = 1'b1;

        // single word, exact latency
        rx_en = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        check("single_ready", in_ready, 1);
        @(posedge clk);
        exp_q.push_back(8'hA5);
        #1 in_valid = 1'b0;
        in_data = 8'h00;
        @(negedge clk);
        check("single_count", fifo_count, 1);
        check("single_req_low0", request, 0);
        @(negedge clk);
        check("lat_out_data", out_data, 8'hA5);
        check("lat_req_low", request, 0);
        check("lat_count", fifo_count, 0);
        @(negedge clk);
        check("lat_req_high", request, 1);
        wait_idle(40, "single_idle");
        check("single_req_done", request, 0);

        // burst into a full FIFO while the bus is stalled
        rx_en = 1'b0;
        push_word(8'h5A, 1'b1);
        wait_req(1'b1, 10, "burst_pre_req");
        for (int i = 0; i < 6; i++)
            push_word(8'(i + 1), i < 4);
        @(negedge clk);
        check("burst_full_count", fifo_count, 4);
        check("burst_full_ready", in_ready, 0);
        rx_en = 1'b1;
        wait_idle(300, "burst_drain");
        check("burst_all_sent", exp_q.size(), 0);

        // pushes and in_data churn during a handshake
        push_word(8'h3C, 1'b1);
        wait_req(1'b1, 10, "stab_req");
        push_word(8'h11, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_data = 8'hF0 ^ 8'(i);
        end
        push_word(8'h22, 1'b1);
        wait_idle(300, "stab_idle");
        check("stab_all_sent", exp_q.size(), 0);

        // push in the IDLE cycle that pops, with two words queued
        rx_en = 1'b0;
        push_word(8'h70, 1'b1);
        wait_req(1'b1, 10, "sim_req");
        push_word(8'h71, 1'b1);
        push_word(8'h72, 1'b1);
        @(negedge clk);
        man_ack = 1'b1;
        wait_req(1'b0, 10, "sim_req_fall");
        man_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sim_count_idle", fifo_count, 2);
        in_valid = 1'b1;
        in_data  = 8'h73;
        check("sim_ready", in_ready, 1);
        exp_q.push_back(8'h73);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("sim_count_hold", fifo_count, 2);
        check("sim_pop_head", out_data, 8'h71);
        rx_en = 1'b1;
        wait_idle(300, "sim_idle");
        check("sim_all_sent", exp_q.size(), 0);

        // asynchronous reset in the middle of REQ
        rx_en = 1'b0;
        push_word(8'h99, 1'b1);
        wait_req(1'b1, 10, "rst_mid_req");
        push_word(8'h98, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_request", request, 0);
        check("arst_count", fifo_count, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_busy", busy, 0);
        check("arst_out_data", out_data, 0);
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_request", request, 0);
        check("post_rst_busy", busy, 0);
        rx_en = 1'b1;
        push_word(8'h4D, 1'b1);
        wait_idle(60, "post_rst_idle");
        check("post_rst_sent", exp_q.size(), 0);

`ifdef HS_OUT_BUS_TIMEOUT_EN
        rx_en = 1'b0;
        push_word(8'h5F, 1'b1);
        wait_req(1'b1, 10, "to_req");
        n = 0;
        while (request === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("to_req_cycles", n, 16);
        check("to_flag", timeout, 1);
        repeat (20) @(negedge clk);
        check("to_sticky", timeout, 1);
        check("to_idle", busy, 0);
        rx_en = 1'b1;
        push_word(8'h60, 1'b1);
        wait_idle(60, "to_next_idle");
        check("to_next_sent", exp_q.size(), 0);
        check("to_still_sticky", timeout, 1);
`else
        n = 0;
        check("no_timeout", timeout, n);
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : global_guard
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/high_speed_out_bus.md
Name: high_speed_out_bus

Overview:
- Transmit end of the asynchronous 4-phase request/acknowledge bus, with bundled data.
- It accepts words from local logic through a valid/ready port and buffers them in a small FIFO.
- It drives each word on out_data, raises request, waits for the synchronized acknowledge to rise, drops request, then waits for acknowledge to fall.
- It pairs with the receive-side block in another clock domain on the same bus.

Parameters:
- DATA_WIDTH, 8: width of in_data and out_data.
- FIFO_DEPTH, 4: FIFO entries. Power of 2, ≥2.
- SETUP_CYCLES, 1: cycles out_data is held stable before request rises. Must be ≥1.
- TIMEOUT_CYCLES, 1024: handshake watchdog limit. Used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  local word offered.
- in_ready  out  1  FIFO can accept a word; equals !full.
- in_data  in  DATA_WIDTH  local word.
- out_data  out  DATA_WIDTH  bundled data to the receiver; registered.
- request  out  1  bus request; registered.
- acknowledge  in  1  bus acknowledge; asynchronous to clk.
- busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- timeout  out  1  sticky watchdog flag. Tied 0 without the optional feature.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - request=0, out_data=0, FIFO empty, fifo_count=0, in_ready=1, busy=0, timeout=0.
  - FSM goes to IDLE; the synchronizer flops clear to 0.
  - Reset mid-handshake drops request immediately and discards the FIFO contents and the in-flight word.
- acknowledge passes through a 2-flop synchronizer to give ack_s. All FSM decisions use ack_s only.
- FIFO push: in_valid && in_ready at a clock edge. in_ready comes from registered occupancy.
  - When full, in_ready=0 and no push occurs, even if a pop happens in the same cycle.
- FSM states:
  - IDLE:
    - If the FIFO is non-empty: pop the head into out_data, load setup counter = SETUP_CYCLES-1, go to SETUP.
    - A word pushed in this same cycle is not popped until the next cycle.
  - SETUP:
    - Hold out_data.
    - When the counter reaches 0: request<=1, go to REQ. Otherwise decrement.
  - REQ:
    - Hold request=1 and out_data.
    - When ack_s=1: request<=0, go to RELEASE.
  - RELEASE:
    - request=0; out_data stays held.
    - When ack_s=0, go to IDLE.
- out_data changes only on the IDLE→SETUP transition. It is never changed while request=1 or while ack_s=1.
- Latency, empty FIFO and idle receiver, SETUP_CYCLES=1:
  - push at edge 0 → out_data valid after edge 1 → request high after edge 2.
  - request falls 1 cycle after ack_s rises, i.e. 3 edges after acknowledge rises.
- Back-to-back words:
  - Each word costs SETUP_CYCLES + sync/handshake cycles + 1 IDLE cycle.
  - Words leave in push order with no loss or duplication.
- fifo_count stays in 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop: occupancy is unchanged.
- acknowledge already high on entry to SETUP (protocol violation): REQ completes immediately after request rises. This is not flagged.

Optional Feature:
- Macro: HS_OUT_BUS_TIMEOUT_EN.
- When defined, a watchdog counter clears on entry to REQ and on entry to RELEASE, and increments each cycle spent in those states.
  - Reaching TIMEOUT_CYCLES in REQ:
    - request<=0, timeout<=1, go to RELEASE; the word is dropped.
  - Reaching TIMEOUT_CYCLES in RELEASE:
    - timeout<=1, go to IDLE.
  - timeout is sticky until reset.
- When not defined:
  - No counter logic; timeout is constant 0.
  - The FSM waits indefinitely in REQ and RELEASE.

Test Plan:
- Reset check: hold rst_n=0, then assert rst_n=0 mid-REQ.
  - Required: request=0, fifo_count=0, in_ready=1 immediately (asynchronous), FSM in IDLE.
- Single word: push 0xA5 into an idle block; model the receiver with a 3-cycle acknowledge delay.
  - Required: out_data=0xA5 one cycle before request=1.
  - Required: request falls 3 cycles after acknowledge rises; the block returns to IDLE with busy=0.
- Burst/full: push 6 words (0x01..0x06) back-to-back with DEPTH=4 and acknowledge held low.
  - Required: in_ready=0 when fifo_count=4 and the excess pushes are refused.
  - Required: after the acknowledge model is enabled, words 0x01..0x04 are transmitted in order.
- Stability: toggle in_data and push words during REQ/RELEASE.
  - Required: out_data is constant while request=1 or ack_s=1.
- Simultaneous push/pop with fifo_count=2 in IDLE.
  - Required: fifo_count stays 2, order is preserved, pointers wrap correctly.
- With HS_OUT_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=16: push a word and never raise acknowledge.
  - Required: request drops after 16 REQ cycles, timeout=1 and stays 1, the next word is sent normally.
